// File: rtl/prco_mmio_uart_pkg.sv
// Shared constants for the memory-mapped UART: register offsets, STATUS layout, TX FSM states.
package prco_mmio_uart_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 4;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  function automatic logic [3:0] satCount4(input int unsigned n);
    return (n > 32'd15) ? 4'd15 : n[3:0];
  endfunction

endpackage

// File: rtl/prco_mmio_uart_if.sv
// Core data-memory request/response bundle seen by the UART register window.
interface prco_mmio_uart_if;
  logic        i_ce;
  logic        i_we;
  logic [15:0] i_addr;
  logic [15:0] i_din;
  logic        q_sel;
  logic        q_ack;
  logic [15:0] q_dout;

  modport master (output i_ce, i_we, i_addr, i_din, input q_sel, q_ack, q_dout);
  modport slave  (input i_ce, i_we, i_addr, i_din, output q_sel, q_ack, q_dout);
endinterface

// File: rtl/prco_sync_fifo.sv
// Synchronous FIFO with async reset to empty; a push into a full FIFO is accepted
// when a pop happens on the same edge.
module prco_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, rdPtr_q;
  logic [AW:0]      count_q;
  logic             doPush, doPop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rdPtr_q];
  assign doPop   = pop_i & ~empty_o;
  assign doPush  = push_i & (~full_o | doPop);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage has no reset; the pointers alone define occupancy.
  always_ff @(posedge i_clk) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/prco_mmio_uart.sv
// Memory-mapped 8N1 UART transmitter: 4-word register window, TX FIFO, serialiser.
module prco_mmio_uart
  import prco_mmio_uart_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'hFF00,
  parameter int          CLK_DIV    = 868,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  prco_mmio_uart_if.slave  bus,
  output logic             q_tx,
  output logic             q_busy
);
  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

  logic [15:0] offset;
  logic        hit, wrTx, wrStatus;
  logic        ack_q, rdStatus_q, ovf_q;
  logic [15:0] statusWord;
  logic        fifoFull, fifoEmpty, pop;
  logic [7:0]  fifoData;
  logic [CW-1:0] fifoCount;
  logic        unusedDinHi;

  tx_state_e   state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bitIdx_q, bitIdx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        baudDone;

  // Unsigned wrap makes addresses below the base fall outside the window too.
  assign offset      = bus.i_addr - BASE_ADDR;
  assign bus.q_sel   = (offset < 16'd4);
  assign hit         = bus.i_ce & bus.q_sel;
  assign wrTx        = hit & bus.i_we & (offset[1:0] == REG_TXDATA);
  assign wrStatus    = hit & bus.i_we & (offset[1:0] == REG_STATUS);
  assign unusedDinHi = ^bus.i_din[15:8];

  prco_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .push_i  (wrTx),
    .data_i  (bus.i_din[7:0]),
    .pop_i   (pop),
    .data_o  (fifoData),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ack_q      <= 1'b0;
      rdStatus_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      ack_q      <= hit;
      rdStatus_q <= hit & ~bus.i_we & (offset[1:0] == REG_STATUS);
      if (wrStatus)                      ovf_q <= 1'b0;
      else if (wrTx & fifoFull & ~pop)   ovf_q <= 1'b1;
    end
  end

  // STATUS is assembled during the ack cycle, so it shows state after the sampling edge.
  always_comb begin
    statusWord                      = '0;
    statusWord[ST_COUNT_LSB +: 4]   = satCount4(32'(fifoCount));
    statusWord[ST_OVF]              = ovf_q;
    statusWord[ST_BUSY]             = q_busy;
    statusWord[ST_EMPTY]            = fifoEmpty;
    statusWord[ST_FULL]             = fifoFull;
  end

  assign bus.q_ack  = ack_q;
  assign bus.q_dout = rdStatus_q ? statusWord : 16'd0;
  assign q_tx       = tx_q;
  assign q_busy     = ~fifoEmpty | (state_q != TX_IDLE);
  assign baudDone   = (baud_q == BAUD_LAST);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= TX_IDLE;
      baud_q   <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bitIdx_q <= bitIdx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

  // STOP chains straight into START when data is waiting, so frames run back-to-back.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q + 16'd1;
    bitIdx_d = bitIdx_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    pop      = 1'b0;
    case (state_q)
      TX_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (!fifoEmpty) begin
          pop     = 1'b1;
          shift_d = fifoData;
          state_d = TX_START;
          tx_d    = 1'b0;
        end
      end
      TX_START: begin
        if (baudDone) begin
          baud_d   = '0;
          bitIdx_d = '0;
          state_d  = TX_DATA;
          tx_d     = shift_q[0];
        end
      end
      TX_DATA: begin
        if (baudDone) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bitIdx_q == 3'd7) begin
            state_d = TX_STOP;
            tx_d    = 1'b1;
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
            tx_d     = shift_q[1];
          end
        end
      end
      TX_STOP: begin
        if (baudDone) begin
          baud_d = '0;
          if (!fifoEmpty) begin
            pop     = 1'b1;
            shift_d = fifoData;
            state_d = TX_START;
            tx_d    = 1'b0;
          end else begin
            state_d = TX_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_prco_mmio_uart.sv
// Scoreboard bench for prco_mmio_uart: cycle-counting reference model, ack/dout monitor, serial decoder.
module tb_prco_mmio_uart;

  localparam logic [15:0] BASE  = 16'hFF00;
  localparam int          DIV   = 4;
  localparam int          DEPTH = 8;

  typedef struct {
    logic [7:0] data;
    int         startEdge;
  } txExp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic qTx, qBusy;

  prco_mmio_uart_if bus();

  prco_mmio_uart #(.BASE_ADDR(BASE), .CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus),
    .q_tx    (qTx),
    .q_busy  (qBusy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: bytes waiting, sticky overflow, edge at which the line frees up.
  int          edgeCnt = 0;
  int          freeAt  = 0;
  int          lastPop = 0;
  bit          mOvf    = 1'b0;
  logic [7:0]  mFifo[$];
  logic [15:0] expAck[$];
  txExp_t      expTx[$];
  bit          popNow;
  logic [7:0]  popByte;
  int          mOff;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h (edge %0d)", name, act, exp, edgeCnt);
    end
  endtask

  function automatic bit inWindow(input logic [15:0] a);
    return (int'(a) >= int'(BASE)) && (int'(a) <= int'(BASE) + 3);
  endfunction

  function automatic bit modelBusy();
    return (mFifo.size() != 0) || (edgeCnt < freeAt);
  endfunction

  function automatic logic [15:0] modelStatus();
    int n;
    n = mFifo.size();
    return 16'(((n > 15 ? 15 : n) << 4) + (int'(mOvf) << 3) + (int'(modelBusy()) << 2)
               + (int'(n == 0) << 1) + int'(n == DEPTH));
  endfunction

  // Each edge: the transmitter takes the oldest byte once the previous frame's 10*DIV cycles are over.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mFifo.delete();
      expAck.delete();
      expTx.delete();
      mOvf   = 1'b0;
      freeAt = 0;
    end else begin
      edgeCnt++;
      popNow = (mFifo.size() != 0) && (edgeCnt >= freeAt);
      if (popNow) begin
        popByte = mFifo.pop_front();
        expTx.push_back('{popByte, edgeCnt});
        freeAt  = edgeCnt + 10 * DIV;
        lastPop = edgeCnt;
      end
      if (bus.i_ce && inWindow(bus.i_addr)) begin
        mOff = int'(bus.i_addr) - int'(BASE);
        if (bus.i_we) begin
          if (mOff == 0) begin
            if (mFifo.size() < DEPTH) mFifo.push_back(bus.i_din[7:0]);
            else mOvf = 1'b1;
          end else if (mOff == 1) begin
            mOvf = 1'b0;
          end
          expAck.push_back(16'h0000);
        end else begin
          expAck.push_back((mOff == 1) ? modelStatus() : 16'h0000);
        end
      end
    end
  end

  // Bus response monitor and per-cycle busy check.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.q_ack || expAck.size() != 0) begin
        checkOutput("ackPresent", bus.q_ack, expAck.size() != 0);
        if (bus.q_ack && expAck.size() != 0) checkOutput("dout", bus.q_dout, expAck[0]);
        expAck.delete();
      end else if (bus.q_dout != 16'h0000) begin
        checkOutput("doutIdle", bus.q_dout, 16'h0000);
      end
      checkOutput("busy", qBusy, modelBusy());
    end
  end

  // Serial decoder: samples mid-bit and checks byte, framing and start edge against the queue.
  bit         inFrame = 1'b0;
  int         frameStart;
  int         decK;
  logic [9:0] bits;
  txExp_t     gotExp;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      inFrame = 1'b0;
    end else if (!inFrame) begin
      if (qTx == 1'b0) begin
        inFrame    = 1'b1;
        frameStart = edgeCnt;
      end
    end else begin
      decK = edgeCnt - frameStart;
      if (decK % DIV == DIV / 2) bits[decK / DIV] = qTx;
      if (decK == 9 * DIV + DIV / 2) begin
        inFrame = 1'b0;
        checkOutput("txExpectedQueued", expTx.size() != 0, 1);
        if (expTx.size() != 0) begin
          gotExp = expTx.pop_front();
          checkOutput("txStartEdge", frameStart, gotExp.startEdge);
          checkOutput("txByte", bits[8:1], gotExp.data);
          checkOutput("txFraming", {bits[9], bits[0]}, 2'b10);
        end
      end
    end
  end

  task automatic applyStimulus(input bit we, input logic [15:0] addr, input logic [15:0] din);
    @(negedge clk);
    bus.i_ce   = 1'b1;
    bus.i_we   = we;
    bus.i_addr = addr;
    bus.i_din  = din;
    #1 checkOutput("sel", bus.q_sel, inWindow(addr));
  endtask

  task automatic busIdle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.i_ce = 1'b0;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((mFifo.size() != 0 || edgeCnt < freeAt + DIV) && guard < 3000) begin
      @(posedge clk);
      #1 guard++;
    end
    checkOutput("drainInTime", guard < 3000, 1);
    checkOutput("txAllSeen", expTx.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int guard;
    int r;
    logic [15:0] a;
    bus.i_ce   = 1'b0;
    bus.i_we   = 1'b0;
    bus.i_addr = 16'h0000;
    bus.i_din  = 16'h0000;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("resetTx", qTx, 1);
    checkOutput("resetBusy", qBusy, 0);
    checkOutput("resetAck", bus.q_ack, 0);
    checkOutput("resetDout", bus.q_dout, 0);

    $display("[TB] status after reset");
    applyStimulus(1'b0, BASE + 16'd1, 16'h0000);
    busIdle(2);

    $display("[TB] single frame 0x55");
    applyStimulus(1'b1, BASE, 16'h1255);
    busIdle(1);
    drain();

    $display("[TB] overflow while a frame is in flight");
    applyStimulus(1'b1, BASE, 16'h00A5);
    busIdle(3);
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b1, BASE, 16'(16'h0030 + i));
    applyStimulus(1'b0, BASE + 16'd1, 16'h0000);
    applyStimulus(1'b1, BASE + 16'd1, 16'h0000);
    applyStimulus(1'b0, BASE + 16'd1, 16'h0000);
    busIdle(1);
    drain();

    $display("[TB] window boundaries");
    applyStimulus(1'b1, 16'h0100, 16'h0077);
    applyStimulus(1'b0, BASE + 16'd3, 16'h0000);
    applyStimulus(1'b1, BASE + 16'd2, 16'h00EE);
    applyStimulus(1'b0, BASE - 16'd1, 16'h0000);
    applyStimulus(1'b1, BASE + 16'd4, 16'h0011);
    applyStimulus(1'b0, BASE + 16'd1, 16'h0000);
    busIdle(2);

    $display("[TB] reset in the middle of a frame");
    applyStimulus(1'b1, BASE, 16'h00C3);
    busIdle(1);
    @(posedge clk);
    #1 guard = 0;
    while (edgeCnt < lastPop + 15 && guard < 100) begin
      @(posedge clk);
      #1 guard++;
    end
    checkOutput("midFrameReached", guard < 100, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 checkOutput("txOnReset", qTx, 1);
    checkOutput("busyOnReset", qBusy, 0);
    @(negedge clk);
    rst = 1'b0;
    busIdle(1);
    applyStimulus(1'b0, BASE + 16'd1, 16'h0000);
    busIdle(60);
    checkOutput("txIdleAfterReset", qTx, 1);

    $display("[TB] push on the pop edge while full");
    applyStimulus(1'b1, BASE, 16'h0081);
    busIdle(1);
    @(posedge clk);
    #1;
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, BASE, 16'(16'h0040 + i));
    busIdle(1);
    guard = 0;
    while (edgeCnt < freeAt - 1 && guard < 100) begin
      @(posedge clk);
      #1 guard++;
    end
    checkOutput("popEdgeReached", guard < 100, 1);
    applyStimulus(1'b1, BASE, 16'h00F7);
    applyStimulus(1'b0, BASE + 16'd1, 16'h0000);
    busIdle(1);
    drain();

    $display("[TB] random traffic");
    for (int n = 0; n < 150; n++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 4)      a = BASE;
      else if (r <= 6) a = BASE + 16'd1;
      else if (r == 7) a = BASE + 16'(2 + $urandom_range(0, 1));
      else             a = 16'($urandom_range(0, 16'hFEFF));
      applyStimulus((r <= 3) ? 1'b1 : 1'($urandom_range(0, 1)), a, 16'($urandom));
      if ($urandom_range(0, 3) != 0) busIdle(int'($urandom_range(1, 30)));
    end
    busIdle(2);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
